// File: rtl/timegen_pkg.sv
`default_nettype none
// ============================================================================
// Module  : timegen_pkg
// Purpose : Shared types and default constants for the time-base generator.
//           - mode_e : RUN (normal second rate) / FAST (stopwatch rate)
//           - default divider constants used as parameter defaults
// Config  : none (TIMEGEN_HOUR_EN is consumed by timegen_param)
// Rev     : 1.0  initial release
// ============================================================================
package timegen_pkg;

  typedef enum logic [0:0] {
    MODE_RUN  = 1'b0,
    MODE_FAST = 1'b1
  } mode_e;

  localparam int c_CLK_PER_SEC_DEF  = 50_000_000;
  localparam int c_SEC_PER_MIN_DEF  = 60;
  localparam int c_MIN_PER_HOUR_DEF = 60;
  localparam int c_FAST_DIV_DEF     = 1;

endpackage : timegen_pkg
`default_nettype wire

// File: rtl/timegen_modcnt.sv
`default_nettype none
// ============================================================================
// Module  : timegen_modcnt
// Purpose : Modulo counter with a run-time terminal value.
//           Counts 0..last while en is high and returns to 0 after last.
//           clr has priority over counting and wrapping.
// Ports   : clk   in   clock, rising edge
//           reset in   asynchronous active-low reset
//           en    in   count enable
//           clr   in   synchronous clear to 0
//           last  in   terminal count (must be <= N-1)
//           count out  current count
//           wrap  out  combinational, en & (count == last)
// Rev     : 1.0  initial release
// ============================================================================
module timegen_modcnt #(
  parameter int N     = 2,
  parameter int WIDTH = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] last,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  assign wrap = en & (count_q == last);

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (wrap) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule : timegen_modcnt
`default_nettype wire

// File: rtl/timegen_param.sv
`default_nettype none
// ============================================================================
// Module  : timegen_param
// Purpose : Parametrised time-base generator. Divides clk into registered
//           single-cycle second/minute ticks (hour optional), exposes the
//           running second/minute counts, and supports pause, synchronous
//           clear and a stopwatch FAST mode switched only at prescaler wraps.
// Config  : `define TIMEGEN_HOUR_EN to build the minute counter and the
//           one_hour tick; otherwise min_count and one_hour are tied to 0.
// Ports   : clk         in   clock, rising edge
//           reset       in   asynchronous active-low reset
//           stopwatch   in   1 requests FAST mode, 0 requests RUN mode
//           pause       in   hold all counters, suppress ticks
//           clear       in   synchronous clear of prescaler/sec/min
//           one_second  out  second tick (registered)
//           one_minute  out  minute tick (registered)
//           one_hour    out  hour tick (registered, hour build only)
//           sec_count   out  current second 0..SEC_PER_MIN-1
//           min_count   out  current minute 0..MIN_PER_HOUR-1
//           fast_active out  current mode is FAST
// Rev     : 1.0  initial release
// ============================================================================
module timegen_param
  import timegen_pkg::*;
#(
  parameter int CLK_PER_SEC  = c_CLK_PER_SEC_DEF,
  parameter int SEC_PER_MIN  = c_SEC_PER_MIN_DEF,
  parameter int MIN_PER_HOUR = c_MIN_PER_HOUR_DEF,
  parameter int FAST_DIV     = c_FAST_DIV_DEF
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            stopwatch,
  input  logic                            pause,
  input  logic                            clear,
  output logic                            one_second,
  output logic                            one_minute,
  output logic                            one_hour,
  output logic [$clog2(SEC_PER_MIN)-1:0]  sec_count,
  output logic [$clog2(MIN_PER_HOUR)-1:0] min_count,
  output logic                            fast_active
);

  localparam int c_psc_w = $clog2(CLK_PER_SEC);
  localparam int c_sec_w = $clog2(SEC_PER_MIN);

  localparam logic [c_psc_w-1:0] c_run_last  = c_psc_w'(CLK_PER_SEC - 1);
  localparam logic [c_psc_w-1:0] c_fast_last = c_psc_w'(FAST_DIV - 1);
  localparam logic [c_sec_w-1:0] c_sec_last  = c_sec_w'(SEC_PER_MIN - 1);

  mode_e mode_q;
  mode_e mode_d;
  logic  one_second_q;
  logic  one_minute_q;
  logic  one_hour_q;

  logic [c_psc_w-1:0] w_psc_last;
  logic [c_psc_w-1:0] w_psc_count_unused;  // prescaler phase is internal only
  logic               w_psc_wrap;
  logic               w_sec_en;
  logic               w_sec_clr;
  logic               w_sec_wrap;
  logic               w_min_tick;
  logic               w_hour_tick;

  // Mode only changes on a prescaler wrap (or clear), so a stopwatch toggle
  // mid-period never produces a shortened period.
  always_comb begin
    mode_d = mode_q;
    if (clear || w_psc_wrap) begin
      mode_d = stopwatch ? MODE_FAST : MODE_RUN;
    end
  end

  assign w_psc_last = (mode_q == MODE_FAST) ? c_fast_last : c_run_last;

  timegen_modcnt #(
    .N     (CLK_PER_SEC),
    .WIDTH (c_psc_w)
  ) u_psc (
    .clk   (clk),
    .reset (reset),
    .en    (~pause),
    .clr   (clear),
    .last  (w_psc_last),
    .count (w_psc_count_unused),
    .wrap  (w_psc_wrap)
  );

  // Seconds advance only on RUN wraps; they are forced to 0 as soon as the
  // next mode is FAST so the count reads 0 for the whole FAST stretch.
  assign w_sec_en  = w_psc_wrap & (mode_q == MODE_RUN);
  assign w_sec_clr = clear | (mode_d == MODE_FAST);

  timegen_modcnt #(
    .N     (SEC_PER_MIN),
    .WIDTH (c_sec_w)
  ) u_sec (
    .clk   (clk),
    .reset (reset),
    .en    (w_sec_en),
    .clr   (w_sec_clr),
    .last  (c_sec_last),
    .count (sec_count),
    .wrap  (w_sec_wrap)
  );

  // In FAST every wrap is also a minute; the tick type follows the mode that
  // was active during the wrapping period.
  assign w_min_tick = (mode_q == MODE_FAST) ? w_psc_wrap : w_sec_wrap;

`ifdef TIMEGEN_HOUR_EN
  if (1) begin : g_min_cnt
    localparam int                 c_min_w    = $clog2(MIN_PER_HOUR);
    localparam logic [c_min_w-1:0] c_min_last = c_min_w'(MIN_PER_HOUR - 1);

    timegen_modcnt #(
      .N     (MIN_PER_HOUR),
      .WIDTH (c_min_w)
    ) u_min (
      .clk   (clk),
      .reset (reset),
      .en    (w_min_tick),
      .clr   (clear),
      .last  (c_min_last),
      .count (min_count),
      .wrap  (w_hour_tick)
    );
  end
`else
  assign min_count   = '0;
  assign w_hour_tick = 1'b0;
`endif

  // Mode FSM and tick registers. Ticks are gated by clear; pause is already
  // folded into the prescaler wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q       <= MODE_RUN;
      one_second_q <= 1'b0;
      one_minute_q <= 1'b0;
      one_hour_q   <= 1'b0;
    end else begin
      mode_q       <= mode_d;
      one_second_q <= w_psc_wrap & ~clear;
      one_minute_q <= w_min_tick & ~clear;
      one_hour_q   <= w_hour_tick & ~clear;
    end
  end

  assign one_second  = one_second_q;
  assign one_minute  = one_minute_q;
  assign one_hour    = one_hour_q;
  assign fast_active = (mode_q == MODE_FAST);

endmodule : timegen_param
`default_nettype wire

// File: tb/tb_timegen_param.sv
`default_nettype none
// ============================================================================
// Module  : tb_timegen_param
// Purpose : Directed self-checking bench for timegen_param with
//           CLK_PER_SEC=10, SEC_PER_MIN=6, MIN_PER_HOUR=4, FAST_DIV=2.
//           Edge k is the k-th rising clk edge after reset release.
// Config  : hour expectations follow TIMEGEN_HOUR_EN.
// Rev     : 1.0  initial release
// ============================================================================
module tb_timegen_param;

`ifdef TIMEGEN_HOUR_EN
  localparam bit HOUR_EN = 1'b1;
`else
  localparam bit HOUR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       stopwatch = 1'b0;
  logic       pause = 1'b0;
  logic       clear = 1'b0;
  logic       one_second;
  logic       one_minute;
  logic       one_hour;
  logic [2:0] sec_count;
  logic [1:0] min_count;
  logic       fast_active;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int eos, eom, eoh, esec, emin, efa;

  always #5 clk = ~clk;

  timegen_param #(
    .CLK_PER_SEC  (10),
    .SEC_PER_MIN  (6),
    .MIN_PER_HOUR (4),
    .FAST_DIV     (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .stopwatch   (stopwatch),
    .pause       (pause),
    .clear       (clear),
    .one_second  (one_second),
    .one_minute  (one_minute),
    .one_hour    (one_hour),
    .sec_count   (sec_count),
    .min_count   (min_count),
    .fast_active (fast_active)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s edge=%0d: got %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input int os, input int om, input int oh,
                           input int sec, input int mn, input int fa);
    check({tag, ".one_second"},  32'(one_second),  os);
    check({tag, ".one_minute"},  32'(one_minute),  om);
    check({tag, ".one_hour"},    32'(one_hour),    oh);
    check({tag, ".sec_count"},   32'(sec_count),   sec);
    check({tag, ".min_count"},   32'(min_count),   mn);
    check({tag, ".fast_active"}, 32'(fast_active), fa);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    #1;
    reset     = 1'b0;
    stopwatch = 1'b0;
    pause     = 1'b0;
    clear     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    cyc   = 0;
  endtask

  initial begin
    // Plain RUN: second ticks every 10 edges, minute every 60, hour at 240.
    do_reset();
    for (int k = 1; k <= 240; k++) begin
      step();
      check_all("run", (k % 10) == 0, (k % 60) == 0, HOUR_EN && (k == 240),
                (k / 10) % 6, HOUR_EN ? (k / 60) % 4 : 0, 0);
    end

    // Mode switch: stopwatch up after edge 13, FAST from edge 20; back to RUN at 30.
    do_reset();
    for (int k = 1; k <= 40; k++) begin
      step();
      if (k < 20) begin
        eos = (k == 10); eom = 0; efa = 0; esec = (k >= 10) ? 1 : 0; emin = 0;
      end else if (k < 30) begin
        eos = (k % 2) == 0; eom = (k > 20) && ((k % 2) == 0); efa = 1; esec = 0;
        emin = HOUR_EN ? ((k - 20) / 2) % 4 : 0;
      end else begin
        eos = (k == 30) || (k == 40); eom = (k == 30); efa = 0;
        esec = (k == 40) ? 1 : 0; emin = HOUR_EN ? 1 : 0;
      end
      eoh = HOUR_EN && (k == 28);
      check_all("mode", eos, eom, eoh, esec, emin, efa);
      if (k == 13) stopwatch = 1'b1;
      if (k == 29) stopwatch = 1'b0;
    end

    // Pause for edges 25..44 delays the tick to 50; pause in a wrap cycle defers it.
    do_reset();
    for (int k = 1; k <= 61; k++) begin
      step();
      eos  = (k == 10) || (k == 20) || (k == 50) || (k == 61);
      esec = (k < 10) ? 0 : (k < 20) ? 1 : (k < 50) ? 2 : (k < 61) ? 3 : 4;
      check_all("pause", eos, 0, 0, esec, 0, 0);
      if (k == 24) pause = 1'b1;
      if (k == 44) pause = 1'b0;
      if (k == 59) pause = 1'b1;
      if (k == 60) pause = 1'b0;
    end

    // Clear at 47 (RUN), clear+stopwatch at 60 (to FAST), clear+pause in a wrap at 64.
    do_reset();
    for (int k = 1; k <= 74; k++) begin
      step();
      if (k < 47) begin
        eos = (k % 10) == 0; eom = 0; esec = k / 10; emin = 0; efa = 0;
      end else if (k < 60) begin
        eos = (k == 57); eom = 0; esec = (k >= 57) ? 1 : 0; emin = 0; efa = 0;
      end else if (k < 64) begin
        eos = (k == 62); eom = (k == 62); esec = 0;
        emin = (HOUR_EN && k >= 62) ? 1 : 0; efa = 1;
      end else begin
        eos = (k == 74); eom = 0; esec = (k == 74) ? 1 : 0; emin = 0; efa = 0;
      end
      check_all("clear", eos, eom, 0, esec, emin, efa);
      if (k == 46) clear = 1'b1;
      if (k == 47) clear = 1'b0;
      if (k == 59) begin clear = 1'b1; stopwatch = 1'b1; end
      if (k == 60) clear = 1'b0;
      if (k == 63) begin clear = 1'b1; pause = 1'b1; stopwatch = 1'b0; end
      if (k == 64) begin clear = 1'b0; pause = 1'b0; end
    end

    // Asynchronous reset while a tick is high, then a full first period.
    do_reset();
    for (int k = 1; k <= 30; k++) begin
      step();
      check_all("pre_arst", (k % 10) == 0, 0, 0, k / 10, 0, 0);
    end
    #2;
    reset = 1'b0;
    #1;
    check_all("arst", 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    cyc   = 0;
    for (int k = 1; k <= 12; k++) begin
      step();
      check_all("post_arst", k == 10, 0, 0, (k >= 10) ? 1 : 0, 0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_timegen_param
`default_nettype wire
